// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared jumpControl opcode encodings for the next-PC sequencer.
// Revision : 1.0
// ============================================================================
package pc_pkg;

    typedef logic [3:0] jump_op_t;

    localparam jump_op_t OP_IDLE  = 4'd0;
    localparam jump_op_t OP_EQZ   = 4'd1;
    localparam jump_op_t OP_NEZ   = 4'd2;
    localparam jump_op_t OP_TEQZ  = 4'd3;
    localparam jump_op_t OP_TNEZ  = 4'd4;
    localparam jump_op_t OP_JUMP  = 4'd5;
    localparam jump_op_t OP_DB    = 4'd6;
    localparam jump_op_t OP_CALL  = 4'd7;
    localparam jump_op_t OP_CALLR = 4'd8;
    localparam jump_op_t OP_RET   = 4'd9;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Purpose  : Circular return-address stack with saturating count, sticky
//            overflow flag and one-cycle underflow pulse.
// Revision : 1.0
// ============================================================================
module ras_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] wdata,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              w_wr;

    // ptr_q names the next free slot; when full it is also the oldest entry,
    // so a push into a full stack overwrites exactly that one.
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == DEPTH_C);
    assign top       = mem_q[ptr_q - PTR_W'(1)];
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign w_wr      = en & push;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (en) begin
            unf_d = pop & empty;
            if (push) begin
                ptr_d = ptr_q + PTR_W'(1);
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (pop && !empty) begin
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch PC register with single-cycle resolution of conditional,
//            indirect, relative and call/return control flow.
// Revision : 1.0
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                IMM_W     = 8,
    parameter int                STEP      = 2,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [3:0]        jumpControl,
    input  logic [ADDR_W-1:0] basePC,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] rs,
    input  logic              t,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] nextPC,
    output logic              taken,
    output logic              rasEmpty,
    output logic              rasOverflow,
    output logic              rasUnderflow
);

    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(STEP);

    jump_op_t          w_op;
    logic [ADDR_W-1:0] w_sext;
    logic [ADDR_W-1:0] w_rel;
    logic [ADDR_W-1:0] w_fall;
    logic [ADDR_W-1:0] w_target;
    logic              w_taken;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_unused;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Holding the opcode at IDLE during reset keeps nextPC at RESET_PC+STEP
    // and blocks any push/pop from reaching the stack.
    assign w_op     = rst ? jump_op_t'(jumpControl) : OP_IDLE;
    assign w_sext   = ADDR_W'($signed(imm));
    assign w_rel    = basePC + w_sext;
    assign w_fall   = pc_q + STEP_C;
    assign w_unused = w_ras_full;

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_rel;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        case (w_op)
            OP_EQZ:   w_taken = (rs == '0);
            OP_NEZ:   w_taken = (rs != '0);
            OP_TEQZ:  w_taken = ~t;
            OP_TNEZ:  w_taken = t;
            OP_JUMP: begin
                w_taken  = 1'b1;
                w_target = rs;
            end
            OP_DB:    w_taken = 1'b1;
            OP_CALL: begin
                w_taken = 1'b1;
                w_push  = 1'b1;
            end
            OP_CALLR: begin
                w_taken  = 1'b1;
                w_target = rs;
                w_push   = 1'b1;
            end
            OP_RET: begin
                w_taken  = ~w_ras_empty;
                w_target = w_ras_top;
                w_pop    = 1'b1;
            end
            default: ;
        endcase
    end

    assign nextPC = w_taken ? w_target : w_fall;
    assign taken  = w_taken;
    assign pc_d   = stall ? pc_q : nextPC;
    assign pc     = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .en        (~stall),
        .push      (w_push),
        .pop       (w_pop),
        .wdata     (basePC + STEP_C),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full),
        .overflow  (rasOverflow),
        .underflow (rasUnderflow)
    );

    assign rasEmpty = w_ras_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed bench for pc_sequencer with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

    localparam int          STEP  = 2;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [3:0]  jc = 4'd0;
    logic [15:0] basePC = '0;
    logic [7:0]  imm = '0;
    logic [15:0] rs = '0;
    logic        t = 1'b0;
    logic [15:0] pc, nextPC;
    logic        taken, rasEmpty, rasOverflow, rasUnderflow;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // reference model state
    logic [15:0] m_pc = RPC;
    logic [15:0] m_ras[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    pc_sequencer #(
        .ADDR_W(16), .IMM_W(8), .STEP(STEP), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .jumpControl(jc),
        .basePC(basePC), .imm(imm), .rs(rs), .t(t),
        .pc(pc), .nextPC(nextPC), .taken(taken),
        .rasEmpty(rasEmpty), .rasOverflow(rasOverflow), .rasUnderflow(rasUnderflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void predict(output bit tk, output logic [15:0] nx,
                                    output bit ps, output bit pp);
        int op;
        int rel;
        logic [15:0] tgt;
        op  = rst ? int'(jc) : 0;
        rel = int'(basePC) + int'($signed(imm));
        tgt = rel[15:0];
        tk = 1'b0; ps = 1'b0; pp = 1'b0;
        case (op)
            1: tk = (rs == 16'd0);
            2: tk = (rs != 16'd0);
            3: tk = (t == 1'b0);
            4: tk = (t == 1'b1);
            5: begin tk = 1'b1; tgt = rs; end
            6: tk = 1'b1;
            7: begin tk = 1'b1; ps = 1'b1; end
            8: begin tk = 1'b1; tgt = rs; ps = 1'b1; end
            9: begin
                pp = 1'b1;
                if (m_ras.size() > 0) begin
                    tk  = 1'b1;
                    tgt = m_ras[$];
                end
            end
            default: ;
        endcase
        nx = tk ? tgt : 16'(m_pc + STEP);
    endfunction

    always @(posedge clk or negedge rst) begin
        bit tk, ps, pp;
        logic [15:0] nx;
        if (!rst) begin
            m_pc = RPC;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!stall) begin
            predict(tk, nx, ps, pp);
            m_unf = pp && (m_ras.size() == 0);
            if (ps) begin
                if (m_ras.size() == DEPTH) begin
                    m_ovf = 1'b1;
                    void'(m_ras.pop_front());
                end
                m_ras.push_back(16'(basePC + STEP));
            end
            if (pp && m_ras.size() > 0) void'(m_ras.pop_back());
            m_pc = nx;
        end
    end

    always @(negedge clk) begin
        bit tk, ps, pp;
        logic [15:0] nx;
        if (started) begin
            predict(tk, nx, ps, pp);
            chk("model_pc", pc, m_pc);
            chk("model_nextPC", nextPC, nx);
            chk("model_taken", taken, tk);
            chk("model_rasEmpty", rasEmpty, m_ras.size() == 0);
            chk("model_rasOverflow", rasOverflow, m_ovf);
            chk("model_rasUnderflow", rasUnderflow, m_unf);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] op, input logic [15:0] b, input logic [7:0] im,
                       input logic [15:0] r, input logic tt, input logic st);
        jc = op; basePC = b; imm = im; rs = r; t = tt; stall = st;
        #2;
    endtask

    initial begin
        logic [15:0] rets [4];
        rets[0] = 16'h0052; rets[1] = 16'h0042; rets[2] = 16'h0032; rets[3] = 16'h0022;

        jc = 4'd7;
        #1 rst = 1'b0;
        started = 1'b1;
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_nextPC", nextPC, 16'h0002);
        chk("rst_taken", taken, 1'b0);
        chk("rst_rasEmpty", rasEmpty, 1'b1);
        chk("rst_rasOverflow", rasOverflow, 1'b0);
        chk("rst_rasUnderflow", rasUnderflow, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("idle0_pc", pc, 16'h0000);
        chk("idle0_nextPC", nextPC, 16'h0002);
        nxt(); drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("idle1_pc", pc, 16'h0002);
        nxt(); drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("idle2_pc", pc, 16'h0004);
        chk("idle2_rasEmpty", rasEmpty, 1'b1);

        nxt(); drv(4'd1, 16'h0010, 8'hFC, 16'h0000, 1'b0, 1'b0);
        chk("eqz_pc", pc, 16'h0006);
        chk("eqz_taken", taken, 1'b1);
        chk("eqz_nextPC", nextPC, 16'h000C);
        nxt(); drv(4'd1, 16'h0010, 8'hFC, 16'h0005, 1'b0, 1'b0);
        chk("eqz_nt_taken", taken, 1'b0);
        chk("eqz_nt_nextPC", nextPC, 16'h000E);
        nxt(); drv(4'd6, 16'hFFFE, 8'h04, 16'h0000, 1'b0, 1'b0);
        chk("db_wrap_nextPC", nextPC, 16'h0002);

        nxt(); drv(4'd7, 16'h0100, 8'h20, 16'h0000, 1'b0, 1'b0);
        chk("call_nextPC", nextPC, 16'h0120);
        nxt(); drv(4'd9, 16'h0120, 8'h00, 16'h0000, 1'b0, 1'b0);
        chk("ret_nextPC", nextPC, 16'h0102);
        chk("ret_taken", taken, 1'b1);
        nxt(); drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("ret_pc", pc, 16'h0102);
        chk("ret_rasEmpty", rasEmpty, 1'b1);

        for (int i = 0; i < 5; i++) begin
            nxt(); drv(4'd8, 16'(16'h0010 * (i + 1)), 8'h00, 16'h1000, 1'b0, 1'b0);
            chk("callr_nextPC", nextPC, 16'h1000);
        end
        for (int i = 0; i < 4; i++) begin
            nxt(); drv(4'd9, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
            if (i == 0) chk("ovf_set", rasOverflow, 1'b1);
            chk("ret_seq_nextPC", nextPC, rets[i]);
        end
        nxt(); drv(4'd9, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("ret_empty_taken", taken, 1'b0);
        chk("ret_empty_nextPC", nextPC, 16'h0024);
        chk("unf_before", rasUnderflow, 1'b0);
        nxt(); drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("unf_pulse", rasUnderflow, 1'b1);
        chk("unf_pc", pc, 16'h0024);
        nxt(); drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("unf_clear", rasUnderflow, 1'b0);

        nxt(); drv(4'd7, 16'h0200, 8'h10, 16'h0, 1'b0, 1'b1);
        chk("stall_taken", taken, 1'b1);
        chk("stall_nextPC", nextPC, 16'h0210);
        chk("stall_pc", pc, 16'h0028);
        nxt(); drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("stall_pc_hold", pc, 16'h0028);
        chk("stall_ras_hold", rasEmpty, 1'b1);

        nxt(); drv(4'd7, 16'h0300, 8'h10, 16'h0, 1'b0, 1'b0);
        nxt(); drv(4'd7, 16'h0400, 8'h10, 16'h0, 1'b0, 1'b0);
        nxt(); drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("pre_rst_pc", pc, 16'h0410);
        chk("pre_rst_rasEmpty", rasEmpty, 1'b0);
        jc = 4'd7; basePC = 16'h0500;
        rst = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 16'h0000);
        chk("mid_rst_rasEmpty", rasEmpty, 1'b1);
        chk("mid_rst_taken", taken, 1'b0);
        chk("mid_rst_nextPC", nextPC, 16'h0002);

        nxt(); rst = 1'b1;
        drv(4'd4, 16'h0040, 8'h08, 16'h0, 1'b1, 1'b0);
        chk("tnez_nextPC", nextPC, 16'h0048);
        nxt(); drv(4'd3, 16'h0080, 8'h80, 16'h0, 1'b0, 1'b0);
        chk("teqz_neg_nextPC", nextPC, 16'h0000);
        nxt(); drv(4'd5, 16'h0, 8'h0, 16'hBEEF, 1'b0, 1'b0);
        chk("jump_nextPC", nextPC, 16'hBEEF);
        nxt(); drv(4'd12, 16'h1234, 8'h10, 16'h0, 1'b1, 1'b0);
        chk("op12_taken", taken, 1'b0);
        chk("op12_nextPC", nextPC, 16'hBEF1);
        nxt(); drv(4'd2, 16'h1000, 8'h7F, 16'h0001, 1'b0, 1'b0);
        chk("nez_nextPC", nextPC, 16'h107F);
        nxt(); drv(4'd9, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("ret_after_rst_taken", taken, 1'b0);
        nxt(); drv(4'd0, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        chk("unf_after_rst", rasUnderflow, 1'b1);
        chk("ovf_cleared_by_rst", rasOverflow, 1'b0);

        nxt();
        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
